// File: rtl/mipi_lane_deskew_ctrl_if.sv
// Lane-side bus of the two-lane deskew controller: raw lane bytes in, aligned pairs and status out.
// master = upstream byte aligners / lane merger side, slave = deskew controller.
interface mipi_lane_deskew_ctrl_if #(
    parameter int SKEW_W = 2
);
    logic              deskew_en;
    logic              lane1_valid;
    logic [7:0]        lane1_data_i;
    logic              lane2_valid;
    logic [7:0]        lane2_data_i;
    logic              align_lane_vld;
    logic [7:0]        lane1_data_o;
    logic [7:0]        lane2_data_o;
    logic              locked;
    logic              skew_err;
    logic              skew_lead;
    logic [SKEW_W-1:0] skew_val;

    modport master (
        output deskew_en, lane1_valid, lane1_data_i, lane2_valid, lane2_data_i,
        input  align_lane_vld, lane1_data_o, lane2_data_o, locked, skew_err,
               skew_lead, skew_val
    );

    modport slave (
        input  deskew_en, lane1_valid, lane1_data_i, lane2_valid, lane2_data_i,
        output align_lane_vld, lane1_data_o, lane2_data_o, locked, skew_err,
               skew_lead, skew_val
    );
endinterface

// File: rtl/mipi_lane_deskew_ctrl.sv
// Two-lane MIPI RX deskew: finds the sync byte per lane, measures skew, delays the leading lane.
// Optional DESKEW_STRIP_SYNC_EN: suppress the aligned sync beat on the output.
module mipi_lane_deskew_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hB8,
    parameter int         MAX_SKEW  = 3,
    parameter int         SKEW_W    = 2
) (
    input logic                   clk_i,
    input logic                   reset,
    mipi_lane_deskew_ctrl_if.slave bus
);
    localparam int                DEPTH   = MAX_SKEW + 1;
    localparam logic [SKEW_W-1:0] MAX_CNT = SKEW_W'(MAX_SKEW);
`ifdef DESKEW_STRIP_SYNC_EN
    localparam bit STRIP_SYNC = 1'b1;
`else
    localparam bit STRIP_SYNC = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, HUNT, ALIGNED, ERROR} state_e;

    state_e            state_q, state_d;
    logic [SKEW_W-1:0] cnt_q, cnt_d;
    logic [SKEW_W-1:0] skew_val_q, skew_val_d;
    logic              skew_lead_q, skew_lead_d;
    logic              hunt_lead_q, hunt_lead_d;
    logic              first_q, first_d;
    logic              vld_q, vld_d;
    logic [7:0]        out1_q, out2_q;
    // Each tap entry is {valid, data}; tap[0] is the registered input.
    logic [8:0]        tap1_q [DEPTH];
    logic [8:0]        tap2_q [DEPTH];
    logic [8:0]        sel1, sel2;
    logic [SKEW_W-1:0] sel1_idx, sel2_idx;
    logic              sync1, sync2;

    assign sync1 = bus.lane1_valid && (bus.lane1_data_i == SYNC_BYTE);
    assign sync2 = bus.lane2_valid && (bus.lane2_data_i == SYNC_BYTE);

    // The leading lane is held back by the measured skew; bypass reads tap 0 on both lanes.
    always_comb begin
        sel1_idx = '0;
        sel2_idx = '0;
        if (bus.deskew_en) begin
            if (skew_lead_q) sel2_idx = skew_val_q;
            else             sel1_idx = skew_val_q;
        end
        sel1 = tap1_q[sel1_idx];
        sel2 = tap2_q[sel2_idx];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        skew_val_d  = skew_val_q;
        skew_lead_d = skew_lead_q;
        hunt_lead_d = hunt_lead_q;
        first_d     = 1'b0;
        if (!bus.deskew_en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sync1 && sync2) begin
                        state_d     = ALIGNED;
                        skew_val_d  = '0;
                        skew_lead_d = 1'b0;
                        first_d     = 1'b1;
                    end else if (sync1 || sync2) begin
                        state_d     = HUNT;
                        cnt_d       = SKEW_W'(1);
                        hunt_lead_d = sync2;
                    end
                end
                HUNT: begin
                    // Only the lagging lane's sync ends the hunt; repeats on the leader are ignored.
                    if (hunt_lead_q ? sync1 : sync2) begin
                        state_d     = ALIGNED;
                        skew_val_d  = cnt_q;
                        skew_lead_d = hunt_lead_q;
                        first_d     = 1'b1;
                    end else if (cnt_q == MAX_CNT) begin
                        state_d = ERROR;
                    end else begin
                        cnt_d = cnt_q + SKEW_W'(1);
                    end
                end
                ALIGNED: begin
                    if (!sel1[8] && !sel2[8])     state_d = IDLE;
                    else if (!sel1[8] || !sel2[8]) state_d = ERROR;
                end
                ERROR: begin
                    if (!bus.lane1_valid && !bus.lane2_valid) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (bus.deskew_en)
            vld_d = (state_q == ALIGNED) && sel1[8] && sel2[8] && !(STRIP_SYNC && first_q);
        else
            vld_d = sel1[8];
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            skew_val_q  <= '0;
            skew_lead_q <= 1'b0;
            hunt_lead_q <= 1'b0;
            first_q     <= 1'b0;
            vld_q       <= 1'b0;
            out1_q      <= '0;
            out2_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tap1_q[i] <= '0;
                tap2_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            skew_val_q  <= skew_val_d;
            skew_lead_q <= skew_lead_d;
            hunt_lead_q <= hunt_lead_d;
            first_q     <= first_d;
            vld_q       <= vld_d;
            out1_q      <= sel1[7:0];
            out2_q      <= sel2[7:0];
            tap1_q[0]   <= {bus.lane1_valid, bus.lane1_data_i};
            tap2_q[0]   <= {bus.lane2_valid, bus.lane2_data_i};
            for (int i = 1; i < DEPTH; i++) begin
                tap1_q[i] <= tap1_q[i-1];
                tap2_q[i] <= tap2_q[i-1];
            end
        end
    end

    assign bus.align_lane_vld = vld_q;
    assign bus.lane1_data_o   = out1_q;
    assign bus.lane2_data_o   = out2_q;
    assign bus.locked         = (state_q == ALIGNED);
    assign bus.skew_err       = (state_q == ERROR);
    assign bus.skew_lead      = skew_lead_q;
    assign bus.skew_val       = skew_val_q;
endmodule

// File: tb/tb_mipi_lane_deskew_ctrl.sv
// Randomized scoreboard bench for mipi_lane_deskew_ctrl: bursts with random skew, bypass and reset.
module tb_mipi_lane_deskew_ctrl;
    localparam int         MAX_SKEW = 3;
    localparam logic [7:0] SYNC     = 8'hB8;
`ifdef DESKEW_STRIP_SYNC_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       locked;
        logic [1:0] sv;
        logic       lead;
        logic       chk_skew;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mipi_lane_deskew_ctrl_if #(.SKEW_W(2)) bus_if();

    mipi_lane_deskew_ctrl #(.SYNC_BYTE(8'hB8), .MAX_SKEW(MAX_SKEW), .SKEW_W(2)) dut (
        .clk_i (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         err_cnt = 0;
    logic [7:0] pay1 [16];
    logic [7:0] pay2 [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic drive(input bit en, input bit v1, input logic [7:0] d1,
                         input bit v2, input logic [7:0] d2);
        bus_if.deskew_en    = en;
        bus_if.lane1_valid  = v1;
        bus_if.lane1_data_i = d1;
        bus_if.lane2_valid  = v2;
        bus_if.lane2_data_i = d2;
    endtask

    task automatic push(input int c, input logic [7:0] d1, input logic [7:0] d2,
                        input logic lk, input logic [1:0] sv, input logic lead, input logic cs);
        exp_t e;
        e.cyc = c; e.d1 = d1; e.d2 = d2; e.locked = lk; e.sv = sv; e.lead = lead; e.chk_skew = cs;
        sb.push_back(e);
    endtask

    task automatic fill_pay(input int L);
        pay1[0] = SYNC;
        pay2[0] = SYNC;
        for (int i = 1; i < L; i++) begin
            pay1[i] = 8'($urandom_range(0, 255));
            pay2[i] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_vld"},   int'(bus_if.align_lane_vld), 0);
        chk({tag, "_d1"},    int'(bus_if.lane1_data_o), 0);
        chk({tag, "_d2"},    int'(bus_if.lane2_data_o), 0);
        chk({tag, "_lock"},  int'(bus_if.locked), 0);
        chk({tag, "_err"},   int'(bus_if.skew_err), 0);
        chk({tag, "_lead"},  int'(bus_if.skew_lead), 0);
        chk({tag, "_sval"},  int'(bus_if.skew_val), 0);
    endtask

    // Reference: d = lane2 sync time minus lane1 sync time. A legal burst yields the byte
    // pairs zipped in order, starting 2 cycles after the later sync; |d| > MAX_SKEW yields none.
    task automatic burst(input int d, input int L, input int abort_at);
        int         ad, s1, s2, e0;
        bit         legal, v1, v2;
        logic [7:0] b1, b2;
        ad    = (d < 0) ? -d : d;
        s1    = (d < 0) ? ad : 0;
        s2    = (d > 0) ? ad : 0;
        legal = (ad <= MAX_SKEW);
        e0    = err_cnt;
        for (int i = 0; i < ad + L + 10; i++) begin
            @(posedge clk); #1;
            v1 = (i >= s1) && (i < s1 + L);
            v2 = (i >= s2) && (i < s2 + L);
            b1 = 8'($urandom_range(0, 255));
            b2 = 8'($urandom_range(0, 255));
            if (v1) b1 = pay1[i - s1];
            if (v2) b2 = pay2[i - s2];
            drive(1'b1, v1, b1, v2, b2);
            if (legal && i >= ad && i < ad + L && !(STRIP && i == ad))
                push(cyc + 2, pay1[i - ad], pay2[i - ad], 1'b1, 2'(ad), (d < 0), 1'b1);
            if (i == abort_at) begin
                #2;
                chk("locked_before_reset", int'(bus_if.locked), 1);
                chk("vld_before_reset", int'(bus_if.align_lane_vld), 1);
                reset = 1'b1;
                #1;
                chk_outputs_zero("mid_reset");
                sb.delete();
                @(posedge clk); #1;
                drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
                @(posedge clk); #1;
                reset = 1'b0;
                repeat (4) @(posedge clk);
                return;
            end
        end
        chk("queue_drained", sb.size(), 0);
        sb.delete();
        chk("skew_err_seen", int'(err_cnt != e0), int'(!legal));
        chk("idle_locked", int'(bus_if.locked), 0);
        chk("idle_skew_err", int'(bus_if.skew_err), 0);
    endtask

    // Bypass reference: output pair = inputs 2 cycles earlier, valid follows lane1_valid.
    task automatic bypass(input int M);
        bit         v1, v2;
        logic [7:0] b1, b2;
        int         e0;
        e0 = err_cnt;
        for (int i = 0; i < M + 6; i++) begin
            @(posedge clk); #1;
            v1 = 1'b0;
            v2 = 1'b0;
            b1 = 8'($urandom_range(0, 255));
            b2 = 8'($urandom_range(0, 255));
            if (i < M) begin
                v1 = 1'($urandom_range(0, 1));
                v2 = 1'($urandom_range(0, 1));
                if (i < 2) begin
                    v1 = 1'b1;
                    b1 = (i == 0) ? 8'hAA : 8'hBB;
                end
            end
            drive(1'b0, v1, b1, v2, b2);
            if (v1) push(cyc + 2, b1, b2, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("bypass_drained", sb.size(), 0);
        sb.delete();
        chk("bypass_locked", int'(bus_if.locked), 0);
        chk("bypass_no_err", err_cnt - e0, 0);
        repeat (3) @(posedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (bus_if.skew_err) err_cnt <= err_cnt + 1;
            if (bus_if.align_lane_vld) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_cycle", cyc, e.cyc);
                    chk("lane1_data", int'(bus_if.lane1_data_o), int'(e.d1));
                    chk("lane2_data", int'(bus_if.lane2_data_o), int'(e.d2));
                    chk("locked", int'(bus_if.locked), int'(e.locked));
                    if (e.chk_skew) begin
                        chk("skew_val", int'(bus_if.skew_val), int'(e.sv));
                        chk("skew_lead", int'(bus_if.skew_lead), int'(e.lead));
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, L;
        reset = 1'b1;
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);

        pay1[0] = SYNC; pay1[1] = 8'h01; pay1[2] = 8'h02;
        pay2[0] = SYNC; pay2[1] = 8'h01; pay2[2] = 8'h02;
        burst(0, 3, -1);
        pay1[1] = 8'h11; pay1[2] = 8'h22;
        pay2[1] = 8'h11; pay2[2] = 8'h22;
        burst(2, 3, -1);
        fill_pay(4); burst(-3, 4, -1);
        fill_pay(4); burst(4, 4, -1);
        fill_pay(3); burst(0, 3, -1);
        fill_pay(3); burst(-4, 3, -1);
        bypass(20);
        fill_pay(6); burst(1, 6, 4);
        fill_pay(5); burst(-2, 5, -1);

        for (int n = 0; n < 40; n++) begin
            d = int'($urandom_range(0, 8)) - 4;
            L = int'($urandom_range(1, 6));
            fill_pay(L);
            burst(d, L, -1);
            if (n % 10 == 9) bypass(8);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
